// File: rtl/clearable_true_dual_port_ram.sv
// rtl/clearable_true_dual_port_ram.sv - true dual-port RAM with byte strobes, read pipeline and clear sequencer
//
// Purpose: single-clock storage with two independent read/write ports. After reset,
// and whenever clear is requested while idle, a sequencer writes CLEAR_VALUE to every
// entry, one entry per cycle. Both ports are held off (ready low) while it runs.
//
// Ports:
//   clock, reset                 single rising-edge clock, asynchronous active-high reset
//   clear                        one-cycle request to restart a full clear (only honoured when idle)
//   busy                         high while the clear sequencer runs
//   port_N_ready                 ~busy; an access is accepted only when this is high
//   port_N_access_enable         access request
//   port_N_write                 1 = write, 0 = read
//   port_N_address               word address (addresses >= DEPTH ignore writes, read CLEAR_VALUE)
//   port_N_write_data/_strobe    write data and per-lane enables
//   port_N_read_data/_valid      read result after READ_LATENCY edges; data holds between reads
module clearable_true_dual_port_ram #(
  parameter int               WIDTH         = 32,
  parameter int               DEPTH         = 16,
  parameter int               BYTE_WIDTH    = 8,
  parameter int               READ_LATENCY  = 1,
  parameter int               WRITE_FIRST   = 0,
  parameter logic [WIDTH-1:0] CLEAR_VALUE   = '0,
  parameter int               ADDRESS_WIDTH = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  parameter int               STROBE_WIDTH  = WIDTH / BYTE_WIDTH
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     clear,
  output logic                     busy,

  output logic                     port_0_ready,
  input  logic                     port_0_access_enable,
  input  logic                     port_0_write,
  input  logic [ADDRESS_WIDTH-1:0] port_0_address,
  input  logic [WIDTH-1:0]         port_0_write_data,
  input  logic [STROBE_WIDTH-1:0]  port_0_write_strobe,
  output logic [WIDTH-1:0]         port_0_read_data,
  output logic                     port_0_read_valid,

  output logic                     port_1_ready,
  input  logic                     port_1_access_enable,
  input  logic                     port_1_write,
  input  logic [ADDRESS_WIDTH-1:0] port_1_address,
  input  logic [WIDTH-1:0]         port_1_write_data,
  input  logic [STROBE_WIDTH-1:0]  port_1_write_strobe,
  output logic [WIDTH-1:0]         port_1_read_data,
  output logic                     port_1_read_valid
);

  localparam logic [ADDRESS_WIDTH-1:0] LAST_ENTRY  = ADDRESS_WIDTH'(DEPTH - 1);
  localparam logic [ADDRESS_WIDTH:0]   DEPTH_LIMIT = (ADDRESS_WIDTH + 1)'(DEPTH);

  typedef enum logic {
    STATE_IDLE,
    STATE_CLEARING
  } state_t;

  state_t                   state;
  state_t                   state_next;
  logic [ADDRESS_WIDTH-1:0] counter;
  logic [ADDRESS_WIDTH-1:0] counter_next;

  logic [WIDTH-1:0] memory [DEPTH];

  logic             in_range_0;
  logic             in_range_1;
  logic             write_0;
  logic             write_1;
  logic             read_0;
  logic             read_1;
  logic [WIDTH-1:0] read_word_0;
  logic [WIDTH-1:0] read_word_1;

  logic [READ_LATENCY-1:0] valid_pipe_0;
  logic [READ_LATENCY-1:0] valid_pipe_1;
  logic [WIDTH-1:0]        data_pipe_0 [READ_LATENCY];
  logic [WIDTH-1:0]        data_pipe_1 [READ_LATENCY];

  // Overlay the strobed lanes of data onto base.
  function automatic logic [WIDTH-1:0] merge_lanes(input logic [WIDTH-1:0]        base,
                                                   input logic [WIDTH-1:0]        data,
                                                   input logic [STROBE_WIDTH-1:0] strobe);
    logic [WIDTH-1:0] result;
    result = base;
    for (int k = 0; k < STROBE_WIDTH; k++) begin
      if (strobe[k]) begin
        result[k*BYTE_WIDTH +: BYTE_WIDTH] = data[k*BYTE_WIDTH +: BYTE_WIDTH];
      end
    end
    return result;
  endfunction

  // Clear sequencer
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state   <= STATE_CLEARING;
      counter <= '0;
    end else begin
      state   <= state_next;
      counter <= counter_next;
    end
  end

  always_comb begin
    state_next   = state;
    counter_next = counter;
    case (state)
      STATE_CLEARING: begin
        // A clear request here is ignored; the running sweep is not restarted.
        if (counter == LAST_ENTRY) begin
          state_next   = STATE_IDLE;
          counter_next = '0;
        end else begin
          counter_next = counter + 1'b1;
        end
      end
      default: begin
        if (clear) begin
          state_next   = STATE_CLEARING;
          counter_next = '0;
        end
      end
    endcase
  end

  assign busy         = (state == STATE_CLEARING);
  assign port_0_ready = ~busy;
  assign port_1_ready = ~busy;

  // Access qualification; everything is dropped while the sequencer owns the array.
  assign in_range_0 = ({1'b0, port_0_address} < DEPTH_LIMIT);
  assign in_range_1 = ({1'b0, port_1_address} < DEPTH_LIMIT);
  assign write_0    = port_0_access_enable & ~busy &  port_0_write & in_range_0;
  assign write_1    = port_1_access_enable & ~busy &  port_1_write & in_range_1;
  assign read_0     = port_0_access_enable & ~busy & ~port_0_write;
  assign read_1     = port_1_access_enable & ~busy & ~port_1_write;

  // Memory array: no reset. Port 1 lanes are assigned before port 0 lanes so that
  // when both ports strobe the same lane of the same word, port 0 wins.
  always_ff @(posedge clock) begin
    if (busy) begin
      memory[counter] <= CLEAR_VALUE;
    end
    for (int k = 0; k < STROBE_WIDTH; k++) begin
      if (write_1 && port_1_write_strobe[k]) begin
        memory[port_1_address][k*BYTE_WIDTH +: BYTE_WIDTH] <= port_1_write_data[k*BYTE_WIDTH +: BYTE_WIDTH];
      end
      if (write_0 && port_0_write_strobe[k]) begin
        memory[port_0_address][k*BYTE_WIDTH +: BYTE_WIDTH] <= port_0_write_data[k*BYTE_WIDTH +: BYTE_WIDTH];
      end
    end
  end

  // Word sampled at the accepting edge. With WRITE_FIRST the other port's same-cycle
  // write is merged in; a port cannot read and write in the same cycle, so only the
  // other port can collide.
  always_comb begin
    read_word_0 = CLEAR_VALUE;
    read_word_1 = CLEAR_VALUE;
    if (in_range_0) begin
      read_word_0 = memory[port_0_address];
    end
    if (in_range_1) begin
      read_word_1 = memory[port_1_address];
    end
    if (WRITE_FIRST != 0) begin
      if (in_range_0 && write_1 && (port_1_address == port_0_address)) begin
        read_word_0 = merge_lanes(read_word_0, port_1_write_data, port_1_write_strobe);
      end
      if (in_range_1 && write_0 && (port_0_address == port_1_address)) begin
        read_word_1 = merge_lanes(read_word_1, port_0_write_data, port_0_write_strobe);
      end
    end
  end

  // Read pipelines. Data stages load only when a valid moves into them, so the last
  // stage (the visible read_data) holds its value between reads.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      valid_pipe_0 <= '0;
      for (int i = 0; i < READ_LATENCY; i++) begin
        data_pipe_0[i] <= '0;
      end
    end else begin
      valid_pipe_0[0] <= read_0;
      if (read_0) begin
        data_pipe_0[0] <= read_word_0;
      end
      for (int i = 1; i < READ_LATENCY; i++) begin
        valid_pipe_0[i] <= valid_pipe_0[i-1];
        if (valid_pipe_0[i-1]) begin
          data_pipe_0[i] <= data_pipe_0[i-1];
        end
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      valid_pipe_1 <= '0;
      for (int i = 0; i < READ_LATENCY; i++) begin
        data_pipe_1[i] <= '0;
      end
    end else begin
      valid_pipe_1[0] <= read_1;
      if (read_1) begin
        data_pipe_1[0] <= read_word_1;
      end
      for (int i = 1; i < READ_LATENCY; i++) begin
        valid_pipe_1[i] <= valid_pipe_1[i-1];
        if (valid_pipe_1[i-1]) begin
          data_pipe_1[i] <= data_pipe_1[i-1];
        end
      end
    end
  end

  assign port_0_read_valid = valid_pipe_0[READ_LATENCY-1];
  assign port_0_read_data  = data_pipe_0[READ_LATENCY-1];
  assign port_1_read_valid = valid_pipe_1[READ_LATENCY-1];
  assign port_1_read_data  = data_pipe_1[READ_LATENCY-1];

endmodule

// File: tb/tb_clearable_true_dual_port_ram.sv
// tb/tb_clearable_true_dual_port_ram.sv - scoreboard bench for clearable_true_dual_port_ram
//
// Two instances share one stimulus stream:
//   a: DEPTH 16, READ_LATENCY 1, WRITE_FIRST 0, CLEAR_VALUE 0
//   b: DEPTH 12, READ_LATENCY 3, WRITE_FIRST 1, CLEAR_VALUE 0xDEADBEEF
// Each read pushes the hand-computed word and due cycle for every instance/port stream;
// the monitor pops on read_valid.
module tb_clearable_true_dual_port_ram;

  localparam int          LAT_A = 1;
  localparam int          LAT_B = 3;
  localparam logic [31:0] CLR_B = 32'hDEADBEEF;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        clear = 1'b0;
  logic        p0_en = 1'b0, p0_wr = 1'b0, p1_en = 1'b0, p1_wr = 1'b0;
  logic [3:0]  p0_ad = '0, p1_ad = '0, p0_st = '0, p1_st = '0;
  logic [31:0] p0_wd = '0, p1_wd = '0;

  logic        busy_a, busy_b, r0a, r1a, r0b, r1b, v0a, v1a, v0b, v1b;
  logic [31:0] q0a, q1a, q0b, q1b;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  typedef struct {
    logic [31:0] data;
    int          due;
  } exp_t;

  exp_t sb [4][$];

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  clearable_true_dual_port_ram #(
    .WIDTH(32), .DEPTH(16), .BYTE_WIDTH(8), .READ_LATENCY(LAT_A),
    .WRITE_FIRST(0), .CLEAR_VALUE(32'h0)
  ) dut_a (
    .clock(clock), .reset(reset), .clear(clear), .busy(busy_a),
    .port_0_ready(r0a), .port_0_access_enable(p0_en), .port_0_write(p0_wr),
    .port_0_address(p0_ad), .port_0_write_data(p0_wd), .port_0_write_strobe(p0_st),
    .port_0_read_data(q0a), .port_0_read_valid(v0a),
    .port_1_ready(r1a), .port_1_access_enable(p1_en), .port_1_write(p1_wr),
    .port_1_address(p1_ad), .port_1_write_data(p1_wd), .port_1_write_strobe(p1_st),
    .port_1_read_data(q1a), .port_1_read_valid(v1a)
  );

  clearable_true_dual_port_ram #(
    .WIDTH(32), .DEPTH(12), .BYTE_WIDTH(8), .READ_LATENCY(LAT_B),
    .WRITE_FIRST(1), .CLEAR_VALUE(CLR_B)
  ) dut_b (
    .clock(clock), .reset(reset), .clear(clear), .busy(busy_b),
    .port_0_ready(r0b), .port_0_access_enable(p0_en), .port_0_write(p0_wr),
    .port_0_address(p0_ad), .port_0_write_data(p0_wd), .port_0_write_strobe(p0_st),
    .port_0_read_data(q0b), .port_0_read_valid(v0b),
    .port_1_ready(r1b), .port_1_access_enable(p1_en), .port_1_write(p1_wr),
    .port_1_address(p1_ad), .port_1_write_data(p1_wd), .port_1_write_strobe(p1_st),
    .port_1_read_data(q1b), .port_1_read_valid(v1b)
  );

  // Stream index = instance*2 + port.
  logic [3:0]  mon_valid;
  logic [31:0] mon_data [4];
  assign mon_valid   = {v1b, v0b, v1a, v0a};
  assign mon_data[0] = q0a;
  assign mon_data[1] = q1a;
  assign mon_data[2] = q0b;
  assign mon_data[3] = q1b;

  // Monitor
  exp_t mon_e;
  always @(negedge clock) begin
    for (int i = 0; i < 4; i++) begin
      if (sb[i].size() > 0 && sb[i][0].due < cyc) begin
        checks++;
        errors++;
        $display("FAIL missing_valid stream %0d: none by cycle %0d, required at cycle %0d", i, cyc, sb[i][0].due);
        void'(sb[i].pop_front());
      end
      if (mon_valid[i]) begin
        if (sb[i].size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_valid stream %0d: valid with data %h at cycle %0d, required none", i, mon_data[i], cyc);
        end else begin
          mon_e = sb[i].pop_front();
          checks++;
          if (mon_data[i] !== mon_e.data) begin
            errors++;
            $display("FAIL read_data stream %0d: got %h required %h", i, mon_data[i], mon_e.data);
          end
          checks++;
          if (cyc != mon_e.due) begin
            errors++;
            $display("FAIL read_latency stream %0d: valid at cycle %0d required %0d", i, cyc, mon_e.due);
          end
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h required %h", name, act, req);
    end
  endtask

  task automatic issue(input logic en0, input logic wr0, input logic [3:0] ad0, input logic [31:0] wd0, input logic [3:0] st0,
                       input logic en1, input logic wr1, input logic [3:0] ad1, input logic [31:0] wd1, input logic [3:0] st1);
    @(negedge clock);
    p0_en = en0; p0_wr = wr0; p0_ad = ad0; p0_wd = wd0; p0_st = st0;
    p1_en = en1; p1_wr = wr1; p1_ad = ad1; p1_wd = wd1; p1_st = st1;
  endtask

  task automatic idle();
    @(negedge clock);
    p0_en = 1'b0;
    p1_en = 1'b0;
    clear = 1'b0;
  endtask

  // Called in the cycle the read is driven; it is accepted on the next edge.
  task automatic push_read(input int port, input logic [31:0] ea, input logic [31:0] eb);
    sb[port].push_back('{ea, cyc + LAT_A});
    sb[2 + port].push_back('{eb, cyc + LAT_B});
  endtask

  task automatic wr(input int port, input logic [3:0] addr, input logic [31:0] data, input logic [3:0] strb);
    if (port == 0) issue(1'b1, 1'b1, addr, data, strb, 1'b0, 1'b0, 4'h0, 32'h0, 4'h0);
    else           issue(1'b0, 1'b0, 4'h0, 32'h0, 4'h0, 1'b1, 1'b1, addr, data, strb);
  endtask

  task automatic rd(input int port, input logic [3:0] addr, input logic [31:0] ea, input logic [31:0] eb);
    if (port == 0) issue(1'b1, 1'b0, addr, 32'h0, 4'h0, 1'b0, 1'b0, 4'h0, 32'h0, 4'h0);
    else           issue(1'b0, 1'b0, 4'h0, 32'h0, 4'h0, 1'b1, 1'b0, addr, 32'h0, 4'h0);
    push_read(port, ea, eb);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy_a"}, {31'h0, busy_a}, 32'h1);
    check({tag, "_busy_b"}, {31'h0, busy_b}, 32'h1);
    check({tag, "_ready"}, {28'h0, r0a, r1a, r0b, r1b}, 32'h0);
    check({tag, "_valid"}, {28'h0, mon_valid}, 32'h0);
    check({tag, "_data_a0"}, q0a, 32'h0);
    check({tag, "_data_a1"}, q1a, 32'h0);
    check({tag, "_data_b0"}, q0b, 32'h0);
    check({tag, "_data_b1"}, q1b, 32'h0);
  endtask

  // Starts sampling in the current cycle (reset just released, state CLEARING).
  task automatic count_busy(input string tag, input int req_a, input int req_b);
    int ca = 0;
    int cb = 0;
    for (int k = 0; k < 40; k++) begin
      if (busy_a) ca++;
      if (busy_b) cb++;
      @(negedge clock);
    end
    check({tag, "_busy_cycles_a"}, 32'(ca), 32'(req_a));
    check({tag, "_busy_cycles_b"}, 32'(cb), 32'(req_b));
  endtask

  task automatic drain();
    for (int k = 0; k < 20; k++) begin
      if (sb[0].size() + sb[1].size() + sb[2].size() + sb[3].size() == 0) break;
      @(negedge clock);
    end
  endtask

  initial begin
    int ca;
    int cb;

    @(negedge clock);
    check_reset_outputs("reset");
    @(negedge clock);
    reset = 1'b0;
    count_busy("init", 16, 12);

    // Freshly cleared contents.
    for (int i = 0; i < 16; i++) rd(0, 4'(i), 32'h0, CLR_B);
    idle();

    // Strobe merge on a single port.
    wr(0, 4'd3, 32'hAABBCCDD, 4'b0101);
    rd(0, 4'd3, 32'h00BB00DD, 32'hDEBBBEDD);

    // Same-address writes from both ports: lane 1 goes to port 0.
    issue(1'b1, 1'b1, 4'd5, 32'h11111111, 4'b0011, 1'b1, 1'b1, 4'd5, 32'h22222222, 4'b0110);
    rd(1, 4'd5, 32'h00221111, 32'hDE221111);

    // Cross-port read/write collisions.
    wr(0, 4'd7, 32'h12345678, 4'hF);
    issue(1'b1, 1'b1, 4'd7, 32'hCAFEF00D, 4'hF, 1'b1, 1'b0, 4'd7, 32'h0, 4'h0);
    push_read(1, 32'h12345678, 32'hCAFEF00D);
    rd(0, 4'd7, 32'hCAFEF00D, 32'hCAFEF00D);
    issue(1'b1, 1'b1, 4'd5, 32'h99999999, 4'b1000, 1'b1, 1'b0, 4'd5, 32'h0, 4'h0);
    push_read(1, 32'h00221111, 32'h99221111);
    rd(1, 4'd5, 32'h99221111, 32'h99221111);

    // Back-to-back reads, then both ports reading one address together.
    wr(1, 4'd1, 32'h01010101, 4'hF);
    wr(0, 4'd2, 32'h02020202, 4'hF);
    rd(1, 4'd1, 32'h01010101, 32'h01010101);
    rd(1, 4'd2, 32'h02020202, 32'h02020202);
    rd(1, 4'd3, 32'h00BB00DD, 32'hDEBBBEDD);
    issue(1'b1, 1'b0, 4'd2, 32'h0, 4'h0, 1'b1, 1'b0, 4'd2, 32'h0, 4'h0);
    push_read(0, 32'h02020202, 32'h02020202);
    push_read(1, 32'h02020202, 32'h02020202);

    // Addresses beyond instance b's depth.
    wr(0, 4'd13, 32'h13131313, 4'hF);
    rd(0, 4'd13, 32'h13131313, CLR_B);
    rd(1, 4'd15, 32'h0, CLR_B);
    idle();
    drain();

    // Clear with an in-flight read, a repeated request and dropped accesses.
    @(negedge clock);
    clear = 1'b1;
    p0_en = 1'b0;
    p1_en = 1'b1; p1_wr = 1'b0; p1_ad = 4'd2;
    push_read(1, 32'h02020202, 32'h02020202);
    @(negedge clock);
    ca = busy_a ? 1 : 0;
    cb = busy_b ? 1 : 0;
    clear = 1'b1;
    p0_en = 1'b1; p0_wr = 1'b1; p0_ad = 4'd0; p0_wd = 32'hFFFFFFFF; p0_st = 4'hF;
    p1_en = 1'b1; p1_wr = 1'b0; p1_ad = 4'd1;
    @(negedge clock);
    if (busy_a) ca++;
    if (busy_b) cb++;
    clear = 1'b0;
    p1_en = 1'b0;
    @(negedge clock);
    p0_en = 1'b0;
    for (int k = 0; k < 30; k++) begin
      if (busy_a) ca++;
      if (busy_b) cb++;
      @(negedge clock);
    end
    check("clear_busy_cycles_a", 32'(ca), 32'd16);
    check("clear_busy_cycles_b", 32'(cb), 32'd12);

    rd(0, 4'd0, 32'h0, CLR_B);
    rd(0, 4'd3, 32'h0, CLR_B);
    rd(1, 4'd5, 32'h0, CLR_B);
    rd(1, 4'd7, 32'h0, CLR_B);
    rd(0, 4'd13, 32'h0, CLR_B);
    wr(0, 4'd6, 32'h600D600D, 4'hF);
    issue(1'b1, 1'b0, 4'd6, 32'h0, 4'h0, 1'b1, 1'b0, 4'd6, 32'h0, 4'h0);
    push_read(0, 32'h600D600D, 32'h600D600D);
    push_read(1, 32'h600D600D, 32'h600D600D);
    idle();
    drain();
    repeat (2) @(negedge clock);

    // Reset with the sequencer counter at 8.
    clear = 1'b1;
    @(negedge clock);
    clear = 1'b0;
    repeat (8) @(negedge clock);
    reset = 1'b1;
    #1;
    check_reset_outputs("midclear_reset");
    repeat (2) @(negedge clock);
    reset = 1'b0;
    count_busy("restart", 16, 12);
    rd(0, 4'd6, 32'h0, CLR_B);
    rd(1, 4'd9, 32'h0, CLR_B);
    idle();
    drain();
    repeat (4) @(negedge clock);

    for (int i = 0; i < 4; i++) check("queue_empty", 32'(sb[i].size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/clearable_true_dual_port_ram.md
Name: clearable_true_dual_port_ram

Overview:
Single-clock true dual-port RAM with two read-write ports, per-byte write strobes, a configurable read pipeline and a defined cross-port collision policy. A built-in clear sequencer writes CLEAR_VALUE to every entry after reset and on request, and holds both ports off with a busy/ready indication while clearing. It is a drop-in storage primitive for register files, scoreboards and shared buffers that need a known initial content without external init logic.

Parameters:
WIDTH, 32, data word width in bits; must be a multiple of BYTE_WIDTH.
DEPTH, 16, number of words; need not be a power of two.
BYTE_WIDTH, 8, bits per write strobe lane.
READ_LATENCY, 1, cycles from an accepted read to read_valid; legal values 1 to 3.
WRITE_FIRST, 0, cross-port read of an address being written in the same cycle: 0 returns old data, 1 returns new merged data.
CLEAR_VALUE, 0, WIDTH-bit value written to every entry by the clear sequencer.
ADDRESS_WIDTH, CLOG2(DEPTH), address width; derived.
STROBE_WIDTH, WIDTH/BYTE_WIDTH, write strobe width; derived.

Ports:
clock  input  1  single clock; all logic on the rising edge.
reset  input  1  asynchronous, active-high reset.
clear  input  1  single-cycle request to start a full clear; honoured only when idle.
busy  output  1  high while the clear sequencer runs.
port_N_ready  output  1  equals ~busy. N = 0 and N = 1 for this and all port_N signals.
port_N_access_enable  input  1  access request; accepted when port_N_ready is high.
port_N_write  input  1  1 = write, 0 = read.
port_N_address  input  ADDRESS_WIDTH  word address.
port_N_write_data  input  WIDTH  write data.
port_N_write_strobe  input  STROBE_WIDTH  per-lane write enable.
port_N_read_data  output  WIDTH  read data; holds its value between reads.
port_N_read_valid  output  1  one-cycle pulse when port_N_read_data updates.

Behaviour:
- Reset (asynchronous): the sequencer enters CLEARING with its counter at 0. busy=1, ready=0, all read_data=0, all read_valid=0, and the read pipeline is flushed. Memory is not reset directly; it is cleared by the sequencer.
- FSM CLEARING:
  - Writes CLEAR_VALUE to entry counter each cycle, then increments the counter.
  - After writing entry DEPTH-1, moves to IDLE the next cycle, so busy is high for exactly DEPTH cycles.
- FSM IDLE:
  - busy=0.
  - clear=1 moves the FSM to CLEARING with the counter at 0 on the next edge.
  - clear while already CLEARING is ignored; the sequence does not restart.
- Reset asserted mid-clear restarts the sequence from entry 0.
- Accesses while busy are dropped: no write, no read_valid.
- Accepted write: memory[address] lane k <= write_data lane k for each k with write_strobe[k]=1. Other lanes are unchanged. An all-zero strobe is a no-op.
- Accepted read:
  - The word is sampled at the accepting edge.
  - read_data and read_valid appear READ_LATENCY edges later (latency 1 means valid the cycle after acceptance).
  - The pipeline accepts one read per cycle per port, fully pipelined.
  - Reads accepted before a clear request still complete during CLEARING.
- Both ports write the same address in the same cycle: lanes strobed by only one port take that port's data; lanes strobed by both take port 0's data.
- One port reads while the other writes the same address in the same cycle:
  - WRITE_FIRST=0: the read returns the pre-write word.
  - WRITE_FIRST=1: the read returns the word as written, with strobe merging applied.
- Both ports read the same address: both return the same data.
- Address >= DEPTH (non-power-of-two DEPTH): writes are ignored; reads return CLEAR_VALUE with valid asserted normally.
- Memory array: no reset, infers block RAM. Only the sequencer and pipeline control registers are reset.

Test Plan:
- Reset release with DEPTH=16 -> busy high for 16 cycles. Then port 0 reads of addresses 0..15 return 0x00000000 with read_valid one cycle after each accepted read.
- Port 0 writes 0xAABBCCDD to address 3 with strobe 4'b0101, then reads address 3 -> 0x00BB00DD.
- Same cycle: port 0 writes 0x11111111 (strobe 4'b0011) and port 1 writes 0x22222222 (strobe 4'b0110) to address 5 -> the word becomes 0x00221111.
- Address 7 holds 0x12345678; port 0 writes 0xCAFEF00D (full strobe) while port 1 reads address 7 -> 0x12345678 with WRITE_FIRST=0, 0xCAFEF00D with WRITE_FIRST=1.
- READ_LATENCY=3: back-to-back reads on port 1 of addresses 1, 2, 3 -> valid pulses on cycles +3, +4, +5 carrying data in order. Then assert clear -> all entries read CLEAR_VALUE. Accesses issued while busy produce no valid and no write.
- Assert reset at clear counter 8 -> the sequence restarts at 0 and busy stays high for 16 more cycles. Outputs read 0 while reset is asserted.
